// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 receive (and future
// transmit) path.
//   ps2_state_e   - frame decoder states
//   PS2_DATA_BITS - payload bits per PS/2 frame
//   odd_parity_ok - checks a payload byte against its odd-parity bit
package ps2_pkg;

  localparam int PS2_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  // Odd parity: the data bits together with the parity bit hold an odd
  // number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic                     par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: small circular FIFO with a valid/pop read side.
//   clk_i, rst_n : clock, synchronous active-low reset
//   push_i/data_i: write strobe and data (accepted when not full, or when
//                  a pop happens in the same cycle)
//   pop_i        : read strobe, ignored while empty
//   data_o       : head entry, valid_o: non-empty, full_o: full
//   level_o      : occupancy, 0..DEPTH
module ps2_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             do_push, do_pop;

  // Pointers carry one wrap bit beyond the address so full and empty differ.
  assign valid_o = (wr_q != rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level_o = wr_q - rd_q;
  assign data_o  = mem_q[rd_q[AW-1:0]];

  assign do_pop  = pop_i & valid_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver.
//   clk_i, rst_n        : peripheral clock, synchronous active-low reset
//   ps2c_i, ps2d_i      : raw, asynchronous PS/2 clock and data pins
//   rx_data_o/rx_valid_o: FIFO head byte / FIFO non-empty
//   rx_ready_i          : pops the head while rx_valid_o is high
//   fifo_level_o        : FIFO occupancy
//   parity_err_o        : 1-cycle pulse, frame dropped on bad parity
//   frame_err_o         : 1-cycle pulse, bad start/stop bit or timeout
//   overflow_o          : 1-cycle pulse, good byte dropped on a full FIFO
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n,
  input  logic                          ps2c_i,
  input  logic                          ps2d_i,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          parity_err_o,
  output logic                          frame_err_o,
  output logic                          overflow_o
);

  localparam int FW  = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BCW = $clog2(PS2_DATA_BITS);

  // Stage: two-flop synchronisers, reset to the idle-high line level
  logic c_meta_q, c_sync_q, d_meta_q, d_sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      c_meta_q <= 1'b1;
      c_sync_q <= 1'b1;
      d_meta_q <= 1'b1;
      d_sync_q <= 1'b1;
    end else begin
      c_meta_q <= ps2c_i;
      c_sync_q <= c_meta_q;
      d_meta_q <= ps2d_i;
      d_sync_q <= d_meta_q;
    end
  end

  // Stage: clock deglitch filter and falling-edge detect
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;

  // The counter runs only while the synchronised level disagrees with the
  // filtered one, so any return to the old level restarts the qualification.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (c_sync_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = c_sync_q;
      else                               fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign fall = filt_q & ~filt_d;

  // Stage: frame decoder, timeout and error pulses
  ps2_state_e               state_q;
  logic [BCW-1:0]           bit_cnt_q;
  logic [PS2_DATA_BITS-1:0] shift_q;
  logic                     par_q;
  logic [TW-1:0]            to_cnt_q;
  logic                     parity_err_q, frame_err_q, overflow_q;
  logic                     timeout, pop, fifo_full, frame_good, push;

  // The edge that would restart the counter wins over an expiring timeout.
  assign timeout    = (state_q != IDLE) && !fall &&
                      (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign pop        = rx_valid_o & rx_ready_i;
  assign frame_good = fall && (state_q == STOP) && d_sync_q &&
                      odd_parity_ok(shift_q, par_q);
  // Push goes straight into the FIFO so the byte appears alongside the
  // registered error pulses, one cycle after the stop edge.
  assign push       = frame_good && (!fifo_full || pop);

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      to_cnt_q     <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;

      if (state_q == IDLE || fall) to_cnt_q <= '0;
      else                         to_cnt_q <= to_cnt_q + 1'b1;

      if (timeout) begin
        state_q     <= IDLE;
        bit_cnt_q   <= '0;
        frame_err_q <= 1'b1;
      end else if (fall) begin
        case (state_q)
          IDLE: begin
            if (!d_sync_q) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          DATA: begin
            shift_q   <= {d_sync_q, shift_q[PS2_DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == BCW'(PS2_DATA_BITS - 1)) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= d_sync_q;
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (!d_sync_q)                            frame_err_q  <= 1'b1;
            else if (!odd_parity_ok(shift_q, par_q))  parity_err_q <= 1'b1;
            else if (fifo_full && !pop)               overflow_q   <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign parity_err_o = parity_err_q;
  assign frame_err_o  = frame_err_q;
  assign overflow_o   = overflow_q;

  // Stage: byte FIFO
  ps2_rx_fifo #(
    .WIDTH (PS2_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (pop),
    .data_o  (rx_data_o),
    .valid_o (rx_valid_o),
    .full_o  (fifo_full),
    .level_o (fifo_level_o)
  );

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: self-checking bench for ps2_rx with a byte scoreboard and a
// table of whole-frame vectors plus hand-written corner sequences.
module tb_ps2_rx;

  localparam int F  = 4;    // FILTER_LEN
  localparam int T  = 600;  // TIMEOUT_CYCLES
  localparam int HB = 30;   // PS/2 half bit period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n, ps2c_i, ps2d_i, rx_ready_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, parity_err_o, frame_err_o, overflow_o;
  logic [2:0] fifo_level_o;

  ps2_rx #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T), .FIFO_DEPTH(4)) dut (
    .clk_i        (clk),
    .rst_n        (rst_n),
    .ps2c_i       (ps2c_i),
    .ps2d_i       (ps2d_i),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .fifo_level_o (fifo_level_o),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int par_cnt = 0, frm_cnt = 0, ovf_cnt = 0;
  int frm_cyc = 0, last_drop = 0;
  logic [7:0] exp_q[$];
  logic pp = 1'b0, pf = 1'b0, po = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       par_bad;
    logic       stop;
    logic       exp_push;
    int         exp_par;
    int         exp_frm;
  } vec_t;
  vec_t vecs[8];

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and pulse monitor, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid_o && rx_ready_i) begin
        if (exp_q.size() == 0) chk("rx_unexpected_byte", int'(rx_data_o), -1);
        else                   chk("rx_data", int'(rx_data_o), int'(exp_q.pop_front()));
      end
      if (parity_err_o || frame_err_o || overflow_o) begin
        chk("pulse_excl", int'(parity_err_o) + int'(frame_err_o) + int'(overflow_o), 1);
        chk("pulse_width", int'({pp, pf, po}), 0);
      end
      if (parity_err_o) par_cnt++;
      if (frame_err_o) begin frm_cnt++; frm_cyc = cyc; end
      if (overflow_o) ovf_cnt++;
      pp = parity_err_o; pf = frame_err_o; po = overflow_o;
    end else begin
      pp = 1'b0; pf = 1'b0; po = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives the first nbits of a frame (start, data LSB first, parity, stop).
  task automatic send_frame(input logic [7:0] b, input logic par_bad,
                            input logic stop_bit, input int nbits,
                            input logic glitch);
    logic [10:0] bits;
    bits = {stop_bit, ~(^b) ^ par_bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d_i = bits[i];
      if (glitch && (i == 3 || i == 6)) begin
        tick(8); ps2c_i = 1'b0; tick(3); ps2c_i = 1'b1; tick(HB - 11);
      end else begin
        tick(HB);
      end
      ps2c_i = 1'b0;
      last_drop = cyc;
      tick(HB);
      ps2c_i = 1'b1;
    end
    ps2d_i = 1'b1;
    tick(2 * HB);
  endtask

  int p0, f0, o0;

  task automatic snap();
    p0 = par_cnt; f0 = frm_cnt; o0 = ovf_cnt;
  endtask

  task automatic chk_err(input string name, input int ep, input int ef, input int eo);
    chk({name, "_par"}, par_cnt - p0, ep);
    chk({name, "_frm"}, frm_cnt - f0, ef);
    chk({name, "_ovf"}, ovf_cnt - o0, eo);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[1] = '{8'h00, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[3] = '{8'hF0, 1'b1, 1'b1, 1'b0, 1, 0};
    vecs[4] = '{8'hF0, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[5] = '{8'h3C, 1'b0, 1'b0, 1'b0, 0, 1};
    vecs[6] = '{8'h3C, 1'b1, 1'b0, 1'b0, 0, 1};
    vecs[7] = '{8'h81, 1'b0, 1'b1, 1'b1, 0, 0};

    rst_n = 1'b0; ps2c_i = 1'b1; ps2d_i = 1'b1; rx_ready_i = 1'b0;
    tick(5);
    @(negedge clk);
    chk("rst_valid", int'(rx_valid_o), 0);
    chk("rst_level", int'(fifo_level_o), 0);
    chk("rst_pulses", int'({parity_err_o, frame_err_o, overflow_o}), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick(5);

    // Single byte, held then popped.
    snap();
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    @(negedge clk);
    chk("b1c_level", int'(fifo_level_o), 1);
    chk("b1c_valid", int'(rx_valid_o), 1);
    chk("b1c_head", int'(rx_data_o), 8'h1C);
    @(posedge clk); #1 rx_ready_i = 1'b1;
    @(posedge clk); #1 rx_ready_i = 1'b0;
    @(negedge clk);
    chk("b1c_pop_valid", int'(rx_valid_o), 0);
    chk("b1c_pop_level", int'(fifo_level_o), 0);
    chk_err("b1c", 0, 0, 0);

    // Frame table with the consumer always ready.
    rx_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      snap();
      if (vecs[i].exp_push) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].par_bad, vecs[i].stop, 11, 1'b0);
      chk_err($sformatf("vec%0d", i), vecs[i].exp_par, vecs[i].exp_frm, 0);
      chk($sformatf("vec%0d_sb_empty", i), exp_q.size(), 0);
    end

    // Fill the FIFO, overflow on the fifth byte, then drain.
    rx_ready_i = 1'b0;
    snap();
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b0, 1'b1, 11, 1'b0);
      if (b == 4) chk("ovf_level4", int'(fifo_level_o), 4);
    end
    chk_err("ovf", 0, 0, 1);
    chk("ovf_level_after", int'(fifo_level_o), 4);
    chk("ovf_head", int'(rx_data_o), 8'h01);
    rx_ready_i = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
    tick(2);
    chk("ovf_drained", exp_q.size(), 0);
    chk("ovf_level0", int'(fifo_level_o), 0);

    // Timeout after start + 3 data bits, then a clean frame.
    snap();
    send_frame(8'h00, 1'b0, 1'b1, 4, 1'b0);
    for (int i = 0; i < T + 200 && frm_cnt == f0; i++) tick(1);
    chk_err("tmo", 0, 1, 0);
    chk("tmo_latency", frm_cyc - last_drop, F + T + 2);
    snap();
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b0);
    chk_err("tmo_5a", 0, 0, 0);
    chk("tmo_5a_sb_empty", exp_q.size(), 0);

    // Short clock glitches are ignored; a zero stop bit drops the frame.
    snap();
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b0, 1'b1, 11, 1'b1);
    chk_err("glitch", 0, 0, 0);
    chk("glitch_sb_empty", exp_q.size(), 0);
    snap();
    send_frame(8'h3C, 1'b0, 1'b0, 11, 1'b0);
    chk_err("stop0", 0, 1, 0);
    chk("stop0_level", int'(fifo_level_o), 0);

    // Reset in the middle of a frame discards it.
    snap();
    send_frame(8'hAA, 1'b0, 1'b1, 6, 1'b0);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    exp_q.push_back(8'h29);
    send_frame(8'h29, 1'b0, 1'b1, 11, 1'b0);
    tick(T + 100);
    chk_err("rst_mid", 0, 0, 0);
    chk("rst_mid_sb_empty", exp_q.size(), 0);
    chk("rst_mid_level", int'(fifo_level_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
